// File: rtl/indata_reorder_pp_pkg.sv
// indata_reorder_pkg: shared types, FSM states and the lane-interleave address permutation
package indata_reorder_pkg;
    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_LINE_LEN = 256;
    localparam int DEF_LANES = 4;
    localparam int ADDR_W = $clog2(DEF_LINE_LEN);
    localparam int LANE_W = $clog2(DEF_LANES);
    typedef logic [DEF_DATA_WIDTH-1:0] sample_t;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_RUN} rstate_t;
    function automatic int perm_addr(input int w, input int line_len, input int lanes);
        return (w % lanes) * (line_len / lanes) + w / lanes;
    endfunction
endpackage

// File: rtl/indata_reorder_pp_if.sv
// indata_reorder_pp_if: sample input and reordered valid/ready output stream
interface indata_reorder_pp_if #(parameter int DATA_WIDTH = 24);
    logic line_start;
    logic valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic valid_out;
    logic ready_in;
    logic last_out;
    modport master (output line_start, valid_in, data_in, ready_in, input data_out, valid_out, last_out);
    modport slave (input line_start, valid_in, data_in, ready_in, output data_out, valid_out, last_out);
endinterface

// File: rtl/indata_reorder_pp_bank_ram.sv
// reorder_bank_ram: simple dual-port RAM holding both banks, bank bit is the address MSB
module reorder_bank_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];
    // one write and one registered read per cycle
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/indata_reorder_pp.sv
// indata_reorder_pp: ping-pong line reorder buffer; TEST_PATTERN_EN adds en_test_pattern to write {bank, index}
module indata_reorder_pp
    import indata_reorder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_LEN = DEF_LINE_LEN,
    parameter int LANES = DEF_LANES,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 sync_rst,
`ifdef TEST_PATTERN_EN
    input  logic                 en_test_pattern,
`endif
    indata_reorder_pp_if.slave   bus,
    output logic                 overflow,
    output logic                 short_line,
    output logic [CNT_WIDTH-1:0] lines_out
);
    localparam int AW = $clog2(LINE_LEN);
    wstate_t ws, ws_n;
    rstate_t rs, rs_n;
    logic wbank, rbank, done, we, rel, issue, pop, tgt_free, ovf_n, short_n, fly, fly_last, l0, l1;
    logic [1:0] full, occ;
    logic [AW-1:0] w, w_n, widx;
    logic [AW:0] rcnt;
    logic [DATA_WIDTH-1:0] wdata, rdata, d0, d1;
`ifdef TEST_PATTERN_EN
    assign wdata = en_test_pattern ? {wbank, (DATA_WIDTH-1)'(widx)} : bus.data_in;
`else
    assign wdata = bus.data_in;
`endif
    // a bank released this cycle already counts as empty for an incoming line
    assign tgt_free = !full[wbank] || (rel && rbank == wbank);
    // write FSM: next state, write strobe and logical write index
    always_comb begin
        ws_n = ws;
        w_n = w;
        widx = w;
        we = 1'b0;
        done = 1'b0;
        ovf_n = 1'b0;
        short_n = 1'b0;
        if (ws == W_FILL) begin
            if (bus.valid_in) begin
                we = 1'b1;
                short_n = bus.line_start;
                widx = bus.line_start ? '0 : w;
                done = !bus.line_start && w == AW'(LINE_LEN - 1);
                w_n = bus.line_start ? AW'(1) : w + 1'b1;
                ws_n = done ? W_IDLE : W_FILL;
            end
        end else if (bus.valid_in && bus.line_start) begin
            we = tgt_free;
            ovf_n = !tgt_free;
            widx = '0;
            w_n = tgt_free ? AW'(1) : '0;
            ws_n = tgt_free ? W_FILL : W_DROP;
        end
    end
    // write FSM state, index, bank select and status pulses
    always_ff @(posedge clk or posedge sync_rst) begin
        if (sync_rst) begin
            ws <= W_IDLE;
            w <= '0;
            wbank <= 1'b0;
            overflow <= 1'b0;
            short_line <= 1'b0;
        end else begin
            ws <= ws_n;
            w <= w_n;
            wbank <= wbank ^ done;
            overflow <= ovf_n;
            short_line <= short_n;
        end
    end
    // bank-full flags: set by the writer, cleared by the reader, independently per bank
    always_ff @(posedge clk or posedge sync_rst) begin
        if (sync_rst) full <= '0;
        else full <= (full & ~(rel ? 2'b01 << rbank : 2'b00)) | (done ? 2'b01 << wbank : 2'b00);
    end
    assign pop = occ != 2'd0 && bus.ready_in;
    assign rel = pop && l0;
    assign issue = (rs == R_IDLE ? full[rbank] : !rcnt[AW]) && ({1'b0, occ} + {2'b0, fly} - {2'b0, pop}) < 3'd2;
    // read FSM: start on a full bank, return to idle after the last transfer
    always_comb begin
        rs_n = rs;
        rs_n = rs == R_IDLE ? (issue ? R_RUN : R_IDLE) : (rel ? R_IDLE : R_RUN);
    end
    // read FSM state, linear read address and the in-flight RAM read
    always_ff @(posedge clk or posedge sync_rst) begin
        if (sync_rst) begin
            rs <= R_IDLE;
            rbank <= 1'b0;
            rcnt <= '0;
            fly <= 1'b0;
            fly_last <= 1'b0;
            lines_out <= '0;
        end else begin
            rs <= rs_n;
            rbank <= rbank ^ rel;
            rcnt <= rel ? '0 : rcnt + {{AW{1'b0}}, issue};
            fly <= issue;
            fly_last <= issue && rcnt == (AW + 1)'(LINE_LEN - 1);
            lines_out <= lines_out + CNT_WIDTH'(rel);
        end
    end
    // two-entry output skid: head d0 drives the bus and only moves on a transfer
    always_ff @(posedge clk or posedge sync_rst) begin
        if (sync_rst) begin
            occ <= '0;
            d0 <= '0;
            d1 <= '0;
            l0 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            occ <= occ + {1'b0, fly} - {1'b0, pop};
            if (occ == 2'd2 ? pop : (fly && (pop || occ == 2'd0))) begin
                d0 <= occ == 2'd2 ? d1 : rdata;
                l0 <= occ == 2'd2 ? l1 : fly_last;
            end
            if (fly && (occ - {1'b0, pop}) == 2'd1) begin
                d1 <= rdata;
                l1 <= fly_last;
            end
        end
    end
    assign bus.valid_out = occ != 2'd0;
    assign bus.data_out = d0;
    assign bus.last_out = l0 && occ != 2'd0;
    reorder_bank_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(AW + 1)) u_ram (
        .clk(clk),
        .we(we),
        .waddr({wbank, AW'(perm_addr(int'(widx), LINE_LEN, LANES))}),
        .wdata(wdata),
        .raddr({rbank, rcnt[AW-1:0]}),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_indata_reorder_pp.sv
// tb_indata_reorder_pp: directed checks of the reorder buffer against a line-level model
module tb_indata_reorder_pp;
    localparam int DW = 24;
    localparam int L = 16;
    localparam int LN = 4;
    localparam int M = L / LN;
    logic clk = 1'b0;
    logic sync_rst = 1'b1;
    logic ls = 1'b0, vi = 1'b0, rdy = 1'b1, rmode = 1'b0;
    logic [DW-1:0] di = '0;
    logic ovf, shrt, ovf1, shrt1;
    logic [15:0] lines, lines1;
    int total = 0, bad = 0;
    int e1[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    logic [DW-1:0] q_d[$];
    logic q_l[$];
    logic [DW-1:0] lbuf[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] got1[$];
    logic gl1[$];
    int pending = 0, mode = 0, ovf_seen = 0, short_seen = 0;
    logic [15:0] exp_lines = '0;
    logic exp_ovf = 1'b0, exp_short = 1'b0, pv = 1'b0, pr = 1'b0;
    logic [DW-1:0] pd = '0;

    indata_reorder_pp_if #(.DATA_WIDTH(DW)) bus ();
    indata_reorder_pp_if #(.DATA_WIDTH(DW)) bus1 ();
    assign bus.line_start = ls;
    assign bus.valid_in = vi;
    assign bus.data_in = di;
    assign bus.ready_in = rdy;
    assign bus1.line_start = ls;
    assign bus1.valid_in = vi;
    assign bus1.data_in = di;
    assign bus1.ready_in = 1'b1;

    indata_reorder_pp #(.DATA_WIDTH(DW), .LINE_LEN(L), .LANES(LN), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .sync_rst(sync_rst),
`ifdef TEST_PATTERN_EN
        .en_test_pattern(1'b0),
`endif
        .bus(bus),
        .overflow(ovf),
        .short_line(shrt),
        .lines_out(lines)
    );
    indata_reorder_pp #(.DATA_WIDTH(DW), .LINE_LEN(L), .LANES(1), .CNT_WIDTH(16)) dut1 (
        .clk(clk),
        .sync_rst(sync_rst),
`ifdef TEST_PATTERN_EN
        .en_test_pattern(1'b0),
`endif
        .bus(bus1),
        .overflow(ovf1),
        .short_line(shrt1),
        .lines_out(lines1)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // line-level model: expected output queue, pulses and line count, checked every cycle
    initial forever begin
        @(negedge clk);
        if (sync_rst) begin
            chk("rst_valid", bus.valid_out, 0);
            chk("rst_lines", lines, 0);
            chk("rst_overflow", ovf, 0);
            q_d.delete();
            q_l.delete();
            lbuf.delete();
            pending = 0;
            mode = 0;
            exp_lines = '0;
            exp_ovf = 1'b0;
            exp_short = 1'b0;
            pv = 1'b0;
        end else begin
            chk("overflow", ovf, exp_ovf);
            chk("short_line", shrt, exp_short);
            chk("lines_out", lines, exp_lines);
            ovf_seen += int'(ovf);
            short_seen += int'(shrt);
            exp_ovf = 1'b0;
            exp_short = 1'b0;
            if (pv && !pr) begin
                chk("stall_valid", bus.valid_out, 1);
                chk("stall_data", bus.data_out, pd);
            end
            if (bus.valid_out) begin
                chk("valid_has_data", q_d.size() != 0, 1);
                if (q_d.size() != 0) begin
                    chk("data_out", bus.data_out, q_d[0]);
                    chk("last_out", bus.last_out, q_l[0]);
                    if (rdy) begin
                        got.push_back(bus.data_out);
                        if (q_l[0]) begin
                            exp_lines++;
                            pending--;
                        end
                        void'(q_d.pop_front());
                        void'(q_l.pop_front());
                    end
                end
            end
            pv = bus.valid_out;
            pr = rdy;
            pd = bus.data_out;
            if (vi) begin
                if (mode != 1) begin
                    if (ls) begin
                        if (pending < 2) begin
                            lbuf.delete();
                            lbuf.push_back(di);
                            mode = 1;
                        end else begin
                            exp_ovf = 1'b1;
                            mode = 2;
                        end
                    end
                end else if (ls) begin
                    exp_short = 1'b1;
                    lbuf.delete();
                    lbuf.push_back(di);
                end else begin
                    lbuf.push_back(di);
                    if (lbuf.size() == L) begin
                        for (int a = 0; a < L; a++) begin
                            q_d.push_back(lbuf[(a % M) * LN + a / M]);
                            q_l.push_back(a == L - 1);
                        end
                        pending++;
                        mode = 0;
                    end
                end
            end
        end
    end

    // capture of the identity-order instance output
    initial forever begin
        @(negedge clk);
        if (!sync_rst && bus1.valid_out) begin
            got1.push_back(bus1.data_out);
            gl1.push_back(bus1.last_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rmode) rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic smp(input logic s, input logic [DW-1:0] d);
        tick();
        ls = s;
        vi = 1'b1;
        di = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            ls = 1'b0;
            vi = 1'b0;
        end
    endtask

    task automatic send_line(input int base);
        for (int i = 0; i < L; i++) smp(i == 0, DW'(base + i));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q_d.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", q_d.size(), 0);
    endtask

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1 sync_rst = 1'b0;
        chk("reset_lines", lines, 0);
        chk("reset_valid", bus.valid_out, 0);
        // 1: one line, permuted order and latency
        got.delete();
        send_line(0);
        tick();
        vi = 1'b0;
        ls = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (!bus.valid_out && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        chk("first_valid_latency", cnt, 2);
        drain(50);
        chk("t1_count", got.size(), 16);
        for (int i = 0; i < 16; i++) if (i < got.size()) chk("t1_order", got[i], e1[i]);
        chk("t1_lines", lines, 1);
        // 2: identity order with one lane
        got1.delete();
        gl1.delete();
        send_line(0);
        idle(1);
        drain(50);
        cnt = 0;
        while (got1.size() < 16 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("t2_count", got1.size(), 16);
        for (int i = 0; i < 16; i++) if (i < got1.size()) begin
            chk("t2_order", got1[i], i);
            chk("t2_last", gl1[i], i == 15);
        end
        chk("t2_lines", lines, 2);
        // 3: both banks full, third line dropped, fourth accepted
        got.delete();
        rdy = 1'b0;
        ovf_seen = 0;
        send_line(100);
        send_line(200);
        send_line(300);
        idle(3);
        chk("t3_overflow_pulses", ovf_seen, 1);
        rdy = 1'b1;
        drain(100);
        chk("t3_lines_a", lines, 4);
        send_line(400);
        idle(1);
        drain(50);
        chk("t3_lines_b", lines, 5);
        chk("t3_count", got.size(), 48);
        if (got.size() == 48) chk("t3_line4_first", got[32], 400);
        // 4: early restart at w=7
        got.delete();
        short_seen = 0;
        for (int i = 0; i < 7; i++) smp(i == 0, DW'(900 + i));
        send_line(100);
        idle(2);
        drain(50);
        chk("t4_short_pulses", short_seen, 1);
        chk("t4_count", got.size(), 16);
        for (int i = 0; i < 16; i++) if (i < got.size()) chk("t4_order", got[i], 100 + e1[i]);
        chk("t4_lines", lines, 6);
        // 5: random back-pressure
        got.delete();
        rmode = 1'b1;
        send_line(300);
        send_line(500);
        idle(1);
        drain(400);
        rmode = 1'b0;
        rdy = 1'b1;
        idle(1);
        chk("t5_lines", lines, 8);
        chk("t5_count", got.size(), 32);
        // 6: reset during readout
        got.delete();
        send_line(700);
        idle(1);
        cnt = 0;
        while (got.size() < 5 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("t6_reached_sample5", got.size(), 5);
        sync_rst = 1'b1;
        @(negedge clk);
        chk("t6_valid_after_rst", bus.valid_out, 0);
        chk("t6_lines_after_rst", lines, 0);
        tick();
        sync_rst = 1'b0;
        got.delete();
        send_line(800);
        idle(1);
        drain(50);
        chk("t6_lines", lines, 1);
        chk("t6_count", got.size(), 16);
        if (got.size() != 0) chk("t6_first", got[0], 800);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/indata_reorder_pp.md
Name: indata_reorder_pp

Overview:
Parametrised single-clock ping-pong reorder buffer for ROIC sample lines.
- Captures LINE_LEN samples per line, starting at a line_start marker.
- Stores each line into one of two banks with a lane-interleaving address permutation.
- Streams the completed bank out linearly over a valid/ready interface.
- Sits between the ROIC deserializer/channel detector and the line packer; adds back-pressure, overflow and short-line detection.

Parameters:
DATA_WIDTH, 24, sample width in bits
LINE_LEN, 256, samples per line; power of 2, >= LANES
LANES, 4, interleave factor; power of 2, divides LINE_LEN; 1 = identity order
CNT_WIDTH, 16, width of the lines_out counter

Ports:
clk  in  1  clock; both write and read sides
sync_rst  in  1  asynchronous active-high reset; all state cleared
line_start  in  1  qualifies the valid_in sample as sample 0 of a new line
valid_in  in  1  input sample valid
data_in  in  DATA_WIDTH  input sample
data_out  out  DATA_WIDTH  reordered sample
valid_out  out  1  data_out valid
ready_in  in  1  downstream ready
last_out  out  1  marks the final sample of a line
overflow  out  1  1-cycle pulse when a line is dropped because the target bank is still full
short_line  out  1  1-cycle pulse when a line is aborted by an early line_start
lines_out  out  CNT_WIDTH  completed output lines; wraps at 2^CNT_WIDTH

Behaviour:
- Reset values: all outputs 0; both banks empty; write bank = 0; read bank = 0; write FSM in W_IDLE; read FSM in R_IDLE.
- Handshake: transfer occurs when valid_out && ready_in. Once asserted, valid_out and data_out hold stable until the transfer completes.

Write FSM:
- W_IDLE: on valid_in && line_start:
  - if the target bank is empty, write sample at index 0 and go to W_FILL;
  - otherwise pulse overflow and go to W_DROP.
- W_FILL: each valid_in writes index w, 0..LINE_LEN-1.
  - Physical address = (w mod LANES)*(LINE_LEN/LANES) + (w / LANES).
  - On w = LINE_LEN-1: mark the bank full, toggle the write bank, go to W_IDLE.
- W_DROP: ignore samples until the next valid_in && line_start, then re-evaluate as in W_IDLE.
- In W_FILL, valid_in && line_start with w != 0 means an early restart:
  - pulse short_line;
  - restart the current bank at index 0 (this sample is written at index 0);
  - the bank is not marked full.
- valid_in low in W_FILL: the write index holds; gaps are allowed.

Read FSM:
- R_IDLE: when the read bank is full, go to R_RUN.
- R_RUN: read addresses 0..LINE_LEN-1 linearly.
  - RAM read latency is 1 cycle; a 2-entry output skid gives 1 sample/cycle under continuous ready.
  - First valid_out appears 2 cycles after the bank-full flag sets.
  - last_out is asserted with address LINE_LEN-1.
  - When the last transfer completes: clear the bank-full flag, toggle the read bank, increment lines_out, go to R_IDLE.
- Simultaneous release and line_start on the same bank in one cycle: the release is visible to the write side that cycle, so the line is accepted with no overflow.
- Simultaneous write-complete on bank A and read-release on bank B: both flags update independently.
- ready_in low: the read address stalls; no sample is lost or duplicated.
- sync_rst mid-line or mid-readout: immediate return to reset values; partial data is discarded.

Optional Feature:
Macro TEST_PATTERN_EN.
- Defined: adds input port en_test_pattern (1 bit).
  - When high, written data is replaced by {bank bit, w zero-extended to DATA_WIDTH-1}.
  - The output order then directly exposes the permutation.
- Undefined: port absent; data_in is written unmodified.

Decomposition:
- Package indata_reorder_pkg holds:
  - sample_t;
  - write FSM state enum (W_IDLE, W_FILL, W_DROP) and read FSM state enum (R_IDLE, R_RUN);
  - constants ADDR_W = $clog2(LINE_LEN) and LANE_W = $clog2(LANES);
  - a function perm_addr(w) implementing the permutation.
- One sub-module, reorder_bank_ram: simple dual-port RAM, 2*LINE_LEN deep, 1-cycle read, bank bit as address MSB.

Test Plan:
1. LINE_LEN=16, LANES=4, ready_in=1, one line with data 0..15 -> output 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; last_out on 15; lines_out=1; first valid_out 2 cycles after the 16th write.
2. LANES=1, line 0..15 -> output identical order 0..15.
3. Three back-to-back lines with ready_in=0 -> lines 1 and 2 fill both banks; line 3 start pulses overflow once and is dropped; after release, line 4 is accepted.
4. line_start at w=7 then 16 samples 100..115 -> short_line pulses once; output contains only 100..115, permuted.
5. ready_in toggled pseudo-randomly at 50% -> output sequence matches the scoreboard exactly; valid_out/data_out are stable while stalled.
6. sync_rst asserted at output sample 5 -> valid_out=0 next cycle; both banks empty; next line is processed normally with lines_out counting from 0.
